// File: rtl/uart_tx_rx.sv
// 8N1 UART transmitter and receiver sharing one clock, CLKS_PER_BIT cycles per bit.
// Define UART_TX_RX_LOOPBACK_EN to feed the receiver from the transmitter instead of i_RX_Serial.
module uart_tx_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP
    } rx_state_t;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_idx, tx_idx_n;
    logic [7:0]  tx_data, tx_data_n;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_idx, rx_idx_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic [7:0]  rx_byte, rx_byte_n;
    logic        rx_dv, rx_dv_n;
    logic        rx_meta, rx_sync;
    logic        rx_in;

`ifdef UART_TX_RX_LOOPBACK_EN
    assign rx_in = o_TX_Active ? o_TX_Serial : 1'b1;
`else
    assign rx_in = i_RX_Serial;
`endif

    // ---------------- transmitter ----------------
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_data  <= tx_data_n;
        end
    end

    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_idx_n    = tx_idx;
        tx_data_n   = tx_data;
        o_TX_Serial = 1'b1;
        o_TX_Active = 1'b0;
        o_TX_Done   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (i_TX_DV) begin
                    tx_data_n  = i_TX_Byte;
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                o_TX_Serial = 1'b0;
                o_TX_Active = 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_DATA: begin
                o_TX_Serial = tx_data[tx_idx];
                o_TX_Active = 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_STOP: begin
                o_TX_Active = 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_CLEANUP;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_CLEANUP: begin
                o_TX_Done  = 1'b1;
                tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_dv    <= 1'b0;
        end else begin
            rx_meta  <= rx_in;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_byte  <= rx_byte_n;
            rx_dv    <= rx_dv_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte;
        rx_dv_n    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_BIT) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_CLEANUP;
                    if (rx_sync) begin
                        rx_byte_n = rx_shift;
                        rx_dv_n   = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_CLEANUP: rx_state_n = RX_IDLE;
            default:    rx_state_n = RX_IDLE;
        endcase
    end

    assign o_RX_DV   = rx_dv;
    assign o_RX_Byte = rx_byte;

endmodule

// File: tb/tb_uart_tx_rx.sv
// Self-checking bench for uart_tx_rx: timestamp-based frame model plus directed and random traffic.
module tb_uart_tx_rx;

    localparam int CPB   = 217;
    localparam int FRAME = 10 * CPB;
    localparam int HALF  = (CPB - 1) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       rx_drv = 1'b1;
    logic       loop_mode = 1'b0;
    logic       tx_active, tx_serial, tx_done, rx_dv;
    logic [7:0] rx_byte;
    logic       rx_line;

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt = 0;
    int done_cnt = 0;

    assign rx_line = loop_mode ? (tx_active ? tx_serial : 1'b1) : rx_drv;

    always #20 clk = ~clk;

    uart_tx_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_TX_DV    (tx_dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Active(tx_active),
        .o_TX_Serial(tx_serial),
        .o_TX_Done  (tx_done),
        .i_RX_Serial(rx_line),
        .o_RX_DV    (rx_dv),
        .o_RX_Byte  (rx_byte)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a 10-bit vector played out CPB cycles per bit; the receiver
    // decides at fixed offsets from the cycle it first sees the synchronized line low.
    bit         m_valid = 1'b0;
    bit         m_tx_busy;
    int         m_tx_k;
    logic [9:0] m_tx_frame;
    logic       m_s1, m_s2;
    bit         m_rx_busy;
    int         m_rx_d;
    logic [7:0] m_rx_sh, m_rx_byte;
    logic       m_rx_dv;

    function automatic logic m_tx_line();
        return (m_tx_busy && m_tx_k < FRAME) ? m_tx_frame[m_tx_k / CPB] : 1'b1;
    endfunction

    always @(posedge clk) begin
        logic line;
        line = loop_mode ? m_tx_line() : rx_drv;
        if (rst) begin
            m_valid   = 1'b1;
            m_tx_busy = 1'b0;
            m_tx_k    = 0;
            m_s1      = 1'b1;
            m_s2      = 1'b1;
            m_rx_busy = 1'b0;
            m_rx_d    = 0;
            m_rx_sh   = 8'h00;
            m_rx_byte = 8'h00;
            m_rx_dv   = 1'b0;
        end else begin
            if (!m_tx_busy) begin
                if (tx_dv) begin
                    m_tx_busy  = 1'b1;
                    m_tx_k     = 0;
                    m_tx_frame = {1'b1, tx_byte, 1'b0};
                end
            end else begin
                m_tx_k++;
                if (m_tx_k > FRAME) m_tx_busy = 1'b0;
            end
            m_rx_dv = 1'b0;
            if (!m_rx_busy) begin
                if (m_s2 == 1'b0) begin
                    m_rx_busy = 1'b1;
                    m_rx_d    = 0;
                end
            end else begin
                m_rx_d++;
                if (m_rx_d == 1 + HALF) begin
                    if (m_s2) m_rx_busy = 1'b0;
                end else if (m_rx_d > 1 + HALF && m_rx_d <= 1 + HALF + 8 * CPB
                             && (m_rx_d - 1 - HALF) % CPB == 0) begin
                    m_rx_sh = {m_s2, m_rx_sh[7:1]};
                end else if (m_rx_d == 1 + HALF + 9 * CPB) begin
                    if (m_s2) begin
                        m_rx_byte = m_rx_sh;
                        m_rx_dv   = 1'b1;
                    end
                end else if (m_rx_d == 2 + HALF + 9 * CPB) begin
                    m_rx_busy = 1'b0;
                end
            end
            m_s2 = m_s1;
            m_s1 = line;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx_serial", 32'(tx_serial), 32'(m_tx_line()));
            chk("tx_active", 32'(tx_active), 32'(m_tx_busy && m_tx_k < FRAME));
            chk("tx_done",   32'(tx_done),   32'(m_tx_busy && m_tx_k == FRAME));
            chk("rx_dv",     32'(rx_dv),     32'(m_rx_dv));
            chk("rx_byte",   32'(rx_byte),   32'(m_rx_byte));
        end
        if (tx_done) done_cnt++;
        if (rx_dv) dv_cnt++;
    end

    task automatic tx_send(input logic [7:0] b);
        tx_dv   = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv   = 1'b0;
        tx_byte = 8'($urandom);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #(40 * 150000);
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int d0, t0, j, pulses, pulse_k;
        logic [7:0] b, last_b;
        bit exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] bb [3] = '{8'h00, 8'hFF, 8'h55};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_active", 32'(tx_active), 32'd0);
        chk("rst_done",   32'(tx_done),   32'd0);
        chk("rst_rx_dv",  32'(rx_dv),     32'd0);
        chk("rst_rx_byte", 32'(rx_byte),  32'h00);

        // loopback of 0x3F
        loop_mode = 1'b1;
        d0 = dv_cnt;
        tx_send(8'h3F);
        repeat (FRAME + 50) @(negedge clk);
        chk("lb_3f_byte", 32'(rx_byte), 32'h3F);
        chk("lb_3f_dvs",  32'(dv_cnt),  32'(d0 + 1));

        // 0xA5 bit pattern and done timing; i_TX_Byte is scrambled after acceptance
        loop_mode = 1'b0;
        pulses = 0;
        pulse_k = -1;
        tx_send(8'hA5);
        for (int k = 0; k <= FRAME + 1; k++) begin
            if (k < FRAME && k % CPB == CPB / 2)
                chk($sformatf("a5_bit%0d", k / CPB), 32'(tx_serial), 32'(exp_a5[k / CPB]));
            if (tx_done) begin
                pulses++;
                pulse_k = k;
            end
            @(negedge clk);
        end
        chk("a5_done_pulses", 32'(pulses), 32'd1);
        chk("a5_done_cycle", 32'(pulse_k), 32'(FRAME));

        // back-to-back loopback
        loop_mode = 1'b1;
        d0 = dv_cnt;
        for (int i = 0; i < 3; i++) begin
            tx_send(bb[i]);
            repeat (FRAME + 1) @(negedge clk);
            chk($sformatf("b2b_byte%0d", i), 32'(rx_byte), 32'(bb[i]));
        end
        repeat (100) @(negedge clk);
        chk("b2b_dvs", 32'(dv_cnt), 32'(d0 + 3));

        // 50-cycle glitch, framing error, then a good frame
        loop_mode = 1'b0;
        d0 = dv_cnt;
        rx_drv = 1'b0;
        repeat (50) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_dvs",  32'(dv_cnt),  32'(d0));
        chk("glitch_byte", 32'(rx_byte), 32'h55);
        rx_frame(8'hC3, 1'b0);
        repeat (400) @(negedge clk);
        chk("ferr_dvs",  32'(dv_cnt),  32'(d0));
        chk("ferr_byte", 32'(rx_byte), 32'h55);
        rx_frame(8'h96, 1'b1);
        repeat (100) @(negedge clk);
        chk("good_byte", 32'(rx_byte), 32'h96);
        chk("good_dvs",  32'(dv_cnt),  32'(d0 + 1));

        // request during a frame is dropped
        loop_mode = 1'b1;
        d0 = dv_cnt;
        t0 = done_cnt;
        tx_send(8'h3F);
        repeat (1000) @(negedge clk);
        tx_send(8'h12);
        repeat (2 * FRAME) @(negedge clk);
        chk("ign_byte",  32'(rx_byte),  32'h3F);
        chk("ign_dvs",   32'(dv_cnt),   32'(d0 + 1));
        chk("ign_dones", 32'(done_cnt), 32'(t0 + 1));

        // reset during data bit 3 (fifth bit of the frame)
        d0 = dv_cnt;
        t0 = done_cnt;
        tx_send(8'hE7);
        repeat (4 * CPB + 50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_serial", 32'(tx_serial), 32'd1);
        chk("abort_active", 32'(tx_active), 32'd0);
        repeat (FRAME + 200) @(negedge clk);
        chk("abort_dones",  32'(done_cnt), 32'(t0));
        chk("abort_dvs",    32'(dv_cnt),   32'(d0));
        chk("abort_byte",   32'(rx_byte),  32'h00);

        // random loopback traffic with stray requests mid-frame
        last_b = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            last_b = b;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            tx_send(b);
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(1, FRAME - 2);
                repeat (j) @(negedge clk);
                tx_send(8'($urandom));
                repeat (FRAME - j) @(negedge clk);
            end else begin
                repeat (FRAME + 1) @(negedge clk);
            end
        end
        repeat (200) @(negedge clk);
        chk("rand_lb_last", 32'(rx_byte), 32'(last_b));

        // random external frames and glitches with concurrent independent TX
        loop_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            fork
                rx_frame(b, ($urandom_range(0, 3) != 0));
                begin
                    repeat ($urandom_range(0, 500)) @(negedge clk);
                    tx_send(8'($urandom));
                end
            join
            repeat (400) @(negedge clk);
            rx_drv = 1'b0;
            repeat ($urandom_range(5, 90)) @(negedge clk);
            rx_drv = 1'b1;
            repeat (200) @(negedge clk);
        end

        repeat (50) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_rx.md
UART_TX_RX -- requirements
Module: uart_tx_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217 (25 MHz clock / 115200 baud), meaning clock cycles per serial bit, legal range 4..65535.
REQ-002 SHALL have port i_Clock  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_TX_DV  input  1  one-cycle pulse requesting transmission of i_TX_Byte.
REQ-005 SHALL have port i_TX_Byte  input  8  byte to transmit, sampled when i_TX_DV is accepted.
REQ-006 SHALL have port o_TX_Active  output  1  high while a frame is being transmitted.
REQ-007 SHALL have port o_TX_Serial  output  1  serial TX line, idle high.
REQ-008 SHALL have port o_TX_Done  output  1  one-cycle pulse at end of stop bit.
REQ-009 SHALL have port i_RX_Serial  input  1  asynchronous serial RX line, idle high.
REQ-010 SHALL have port o_RX_DV  output  1  one-cycle pulse when o_RX_Byte holds a new valid byte.
REQ-011 SHALL have port o_RX_Byte  output  8  last received byte.

Function
REQ-012 Frame SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each exactly CLKS_PER_BIT cycles.
REQ-013 TX FSM SHALL have states IDLE, START, DATA, STOP, CLEANUP; IDLE drives o_TX_Serial=1, o_TX_Active=0.
REQ-014 In IDLE, i_TX_DV=1 SHALL latch i_TX_Byte, assert o_TX_Active and drive the start bit from the next cycle.
REQ-015 TX SHALL hold START, each DATA bit and STOP for CLKS_PER_BIT cycles each; total frame 10*CLKS_PER_BIT cycles.
REQ-016 On leaving STOP, TX SHALL pulse o_TX_Done for exactly one cycle, deassert o_TX_Active in that cycle, and return to IDLE via CLEANUP (one cycle, line high).
REQ-017 i_TX_DV asserted outside IDLE SHALL be ignored; no queuing; latched byte unaffected by i_TX_Byte changes mid-frame.
REQ-018 RX input SHALL pass through a two-flop synchronizer before use.
REQ-019 RX FSM SHALL have states IDLE, START, DATA, STOP, CLEANUP.
REQ-020 RX IDLE SHALL move to START on synchronized line = 0.
REQ-021 RX START SHALL wait (CLKS_PER_BIT-1)/2 cycles and resample; if 0 enter DATA, else (glitch) return to IDLE with no output.
REQ-022 RX DATA SHALL sample every CLKS_PER_BIT cycles from start-bit midpoint, shifting 8 bits LSB first.
REQ-023 RX STOP SHALL sample after CLKS_PER_BIT cycles; if 1, update o_RX_Byte and pulse o_RX_DV one cycle; if 0 (framing error), discard byte, no o_RX_DV.
REQ-024 RX CLEANUP SHALL last one cycle then return to IDLE; o_RX_Byte SHALL hold its value until the next valid frame.
REQ-025 TX and RX SHALL operate independently and concurrently.

Reset
REQ-026 i_Reset sampled high SHALL force both FSMs to IDLE and clear all counters within that cycle.
REQ-027 Reset values: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=8'h00.
REQ-028 Reset mid-frame SHALL abort the frame; no o_TX_Done or o_RX_DV for the aborted frame.

Configuration
REQ-029 With macro UART_TX_RX_LOOPBACK_EN defined, RX input SHALL be (o_TX_Active ? o_TX_Serial : 1) and i_RX_Serial ignored.
REQ-030 Without UART_TX_RX_LOOPBACK_EN, RX input SHALL be i_RX_Serial.

Verification
REQ-031 TX 8'h3F with TX line fed to RX (line forced 1 when o_TX_Active=0), CLKS_PER_BIT=217, 40 ns clock -> o_RX_DV pulse with o_RX_Byte=8'h3F.
REQ-032 TX 8'hA5 -> o_TX_Serial bits 0,1,0,1,0,0,1,0,1,1 each 217 cycles; o_TX_Done one pulse 2170 cycles after start.
REQ-033 Loopback bytes 8'h00, 8'hFF, 8'h55 back to back -> three o_RX_DV pulses with matching bytes.
REQ-034 RX low glitch of 50 cycles -> no o_RX_DV, RX back in IDLE; frame with stop bit 0 -> no o_RX_DV, o_RX_Byte unchanged.
REQ-035 i_TX_DV with 8'h12 mid-frame of 8'h3F -> ignored, only 8'h3F sent.
REQ-036 i_Reset at bit 4 of TX frame -> next cycle o_TX_Serial=1, o_TX_Active=0, no o_TX_Done, no o_RX_DV.
